regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-read-port register file for the pipelined CPU datapath.
//  Generalises the single-write/dual-read file in width, depth and read-port count.
//  Adds an optional hardwired-zero entry 0 and a sequenced bulk-clear engine (one entry/cycle, busy/done handshake).
//  Optionally adds same-cycle write-to-read forwarding.
//  Sits between the decode stage (read ports) and the writeback stage (write port).
// PARAMETERS
//  DATA_W    32  bits per entry
//  ADDR_W    5   address width; DEPTH = 1<<ADDR_W entries
//  NUM_RD    2   number of independent combinational read ports (1..4)
//  ZERO_REG  1   1: entry 0 always reads 0, writes to it dropped; 0: entry 0 is ordinary
// PORTS
//  clk       in   1               rising-edge clock
//  rst_n     in   1               asynchronous active-low reset
//  ra        in   NUM_RD*ADDR_W   read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd        out  NUM_RD*DATA_W   read data, port k at [k*DATA_W +: DATA_W]
//  we        in   1               write enable
//  wa        in   ADDR_W          write address
//  wd        in   DATA_W          write data
//  clr_req   in   1               bulk-clear request (level, sampled on clk)
//  clr_busy  out  1               clear sweep in progress
//  clr_done  out  1               one-cycle pulse when sweep finishes
// BEHAVIOUR
//  - Reset (rst_n=0, async): every entry := 0; FSM := IDLE; clr_ptr := 0; clr_busy=0; clr_done=0.
//  - Reads: combinational, zero latency. rd[k] = mem[ra[k]].
//    With ZERO_REG=1, ra[k]==0 -> rd[k]=0 regardless of contents.
//  - Write: on posedge clk, if we && FSM==IDLE && !(ZERO_REG && wa==0): mem[wa] := wd.
//    Visible on read ports the cycle after the edge, unless forwarding is enabled.
//  - FSM states: IDLE, CLEAR, DONE.
//    IDLE  -> CLEAR when clr_req=1; clr_ptr := 0.
//    CLEAR: each cycle mem[clr_ptr] := 0, clr_ptr += 1. When clr_ptr==DEPTH-1, that entry is cleared -> DONE.
//    DONE  -> IDLE unconditionally after one cycle.
//  - clr_busy = 1 in CLEAR.
//  - clr_done = 1 in DONE only: exactly DEPTH+1 cycles after the edge that accepted clr_req.
//  - External writes while in CLEAR or DONE are dropped, with no error flag. The source must hold off while clr_busy=1.
//  - clr_req while in CLEAR or DONE is ignored; it is not queued.
//    If clr_req is still high in IDLE after DONE, a new sweep starts.
//  - Reads during CLEAR return current contents: entries below clr_ptr already read 0.
//  - clr_ptr is ADDR_W bits wide; the terminal-count compare prevents wrap.
//  - Read and write on the same entry in the same cycle: read returns old data unless forwarding is enabled.
//  - rst_n asserted mid-sweep: FSM aborts to IDLE and the whole array is zeroed. No clr_done pulse.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   - If we && FSM==IDLE && wa==ra[k] && !(ZERO_REG && wa==0), then rd[k]=wd in the same cycle (write-first).
//  REGFILE_BYPASS_EN undefined:
//   - Pure read-old-data behaviour; no wa/ra comparators are built.
// TESTING
//  1 Reset: rst_n=0 asynchronously, mid-cycle -> all rd=0 immediately, clr_busy=0, clr_done=0.
//  2 Write/read: we=1, wa=5, wd=32'hDEADBEEF; next cycle ra0=5 -> rd0=32'hDEADBEEF. ra1=0 -> rd1=0.
//  3 Zero reg: ZERO_REG=1, write wa=0, wd=32'h1234 -> rd(0)=0.
//    ZERO_REG=0, same write -> rd(0)=32'h1234.
//  4 Bypass: same-cycle we=1, wa=7, wd=32'hA5A5A5A5, ra0=7
//    -> rd0=32'hA5A5A5A5 with REGFILE_BYPASS_EN; old value (0) without.
//  5 Clear: fill all 32 entries with 32'hFFFFFFFF, pulse clr_req
//    -> clr_busy high for 32 cycles, clr_done high on cycle 33, then all entries read 0.
//    A write issued at cycle 10 of the sweep is dropped.
//  6 Abort: start clear, drop rst_n at cycle 12 -> FSM IDLE, clr_busy=0, no clr_done, all entries 0.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with optional zero entry and sequenced bulk clear
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wa,
    input  logic [DATA_W-1:0]          wd,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       clr_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wa_is_zero;
    logic                wr_en;
    logic                clr_last;

    assign wa_is_zero = (ZERO_REG != 0) && (wa == '0);
    assign wr_en      = we && (state == S_IDLE) && !wa_is_zero;
    assign clr_last   = (clr_ptr == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (clr_req) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clr_busy = 1'b1;
                if (clr_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                clr_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Pointer parks at zero outside a sweep so every sweep starts from entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr <= '0;
        end else if (state == S_CLEAR && !clr_last) begin
            clr_ptr <= clr_ptr + 1'b1;
        end else begin
            clr_ptr <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == S_CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_en) begin
            mem[wa] <= wd;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = ra[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem[addr];
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
            end
`ifdef REGFILE_BYPASS_EN
            // wr_en already excludes the hardwired zero entry and non-idle states.
            if (wr_en && (wa == addr)) begin
                data = wd;
            end
`endif
        end

        assign rd[k*DATA_W +: DATA_W] = data;
    end

endmodule
